// File: rtl/key_arbiter.sv
// key_arbiter: queues button press events per key and offers them round-robin over a valid/ready handshake.
// Optional per-key debounce filter enabled by defining KEY_ARBITER_DEBOUNCE_EN.
module key_arbiter #(
  parameter int N_KEYS     = 4,
  parameter int DEB_CYCLES = 16,
  parameter int KW         = (N_KEYS > 2) ? $clog2(N_KEYS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] btn,
  input  logic              key_ready,
  output logic              key_valid,
  output logic [KW-1:0]     key_id,
  output logic [N_KEYS-1:0] pending,
  output logic              overrun
);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t            state_q, state_d;
  logic [N_KEYS-1:0] filt, prev_q, press, pend_q, pend_d, clr;
  logic [KW-1:0]     id_q, id_d, ptr_q, ptr_d, win;
  logic              found, grant, ovr_q, ovr_d;

  if (N_KEYS < 2 || N_KEYS > 8 || DEB_CYCLES < 1 || DEB_CYCLES > 65535) begin : g_bad_param
    $error("key_arbiter: parameter out of range");
  end

`ifdef KEY_ARBITER_DEBOUNCE_EN
  logic [N_KEYS-1:0] filt_q;
  logic [15:0]       cnt_q [N_KEYS];
  // A level is accepted only after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= '0;
      for (int i = 0; i < N_KEYS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (btn[i] == filt_q[i]) cnt_q[i] <= '0;
        else if (cnt_q[i] == 16'(DEB_CYCLES - 1)) begin
          filt_q[i] <= btn[i];
          cnt_q[i]  <= '0;
        end else cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end
  assign filt = filt_q;
`else
  assign filt = btn;
`endif

  assign press = filt & ~prev_q;

  // Round-robin search starting at ptr_q, wrapping past the top index.
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N_KEYS) j = j - N_KEYS;
      if (!found && pend_q[KW'(j)]) begin
        found = 1'b1;
        win   = KW'(j);
      end
    end
  end

  assign grant  = (state_q == IDLE) && found;
  assign clr    = grant ? N_KEYS'(1) << win : '0;
  assign pend_d = (pend_q & ~clr) | press;
  assign ovr_d  = ovr_q | |(press & pend_q & ~clr);

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (grant) begin
      state_d = OFFER;
      id_d    = win;
    end else if (state_q == OFFER && key_ready) begin
      state_d = IDLE;
      ptr_d   = (id_q == KW'(N_KEYS - 1)) ? '0 : id_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      id_q    <= '0;
      ptr_q   <= '0;
      pend_q  <= '0;
      prev_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      prev_q  <= filt;
      ovr_q   <= ovr_d;
    end
  end

  assign key_valid = (state_q == OFFER);
  assign key_id    = id_q;
  assign pending   = pend_q;
  assign overrun   = ovr_q;
endmodule

// File: doc/key_arbiter.md
KEY_ARBITER -- requirements
Module: key_arbiter

Interface
REQ-001 Parameter: N_KEYS, 4, number of button inputs (2..8).
REQ-002 Parameter: DEB_CYCLES, 16, consecutive stable cycles required by the debounce filter (1..65535).
REQ-003 Parameter: KW, ceil(log2(N_KEYS)) with minimum 1, width of key_id.
REQ-004 Port: clk  input  1  sole clock; all state SHALL update on its rising edge only.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: btn  input  N_KEYS  raw button levels; bit i is key i.
REQ-007 Port: key_ready  input  1  consumer accepts the offered key.
REQ-008 Port: key_valid  output  1  a key event is offered.
REQ-009 Port: key_id  output  KW  index of the offered key.
REQ-010 Port: pending  output  N_KEYS  per-key queued-event flags.
REQ-011 Port: overrun  output  1  sticky flag: a press was lost.

Function
REQ-012 Per key, a level register prev[i] SHALL hold the previous filtered level; a press event SHALL occur on a clock edge where filtered level is 1 and prev[i] is 0.
REQ-013 A press event on key i SHALL set pending[i] at that edge.
REQ-014 A press event on key i while pending[i] is already 1 and not being cleared that edge SHALL be dropped and SHALL set overrun.
REQ-015 A release (1->0) SHALL generate no event.
REQ-016 FSM states SHALL be IDLE and OFFER; reset state IDLE.
REQ-017 IDLE, pending nonzero: select winner by round-robin starting at index ptr, ascending, wrapping N_KEYS-1 -> 0; load key_id, clear pending[winner], go OFFER; key_valid=1 from the next cycle.
REQ-018 IDLE, pending zero: stay IDLE, key_valid=0; key_ready ignored.
REQ-019 OFFER: key_valid=1, key_id held stable until a cycle with key_ready=1; on that edge go IDLE and set ptr = (key_id+1) mod N_KEYS.
REQ-020 Back-to-back: after a handshake, the next grant SHALL occur on the following edge (one IDLE cycle, key_valid=0 for exactly one cycle).
REQ-021 A press event on key i in the same edge its pending[i] is cleared by a grant SHALL leave pending[i]=1 (new event, no overrun).
REQ-022 A press on the currently offered key SHALL set pending for it (queued behind the offer).
REQ-023 Latency without debounce: key_valid SHALL rise 2 edges after the first edge sampling btn[i]=1, when IDLE with empty pending.
REQ-024 Simultaneous presses SHALL all be queued; grant order SHALL follow REQ-017.

Reset
REQ-025 On reset edge: key_valid=0, key_id=0, pending=0, overrun=0, ptr=0, prev=0, state IDLE, debounce counters=0 and filtered levels=0.
REQ-026 Reset mid-OFFER SHALL discard the offered and all queued events; key_valid low after that edge.
REQ-027 A button held through reset release SHALL produce one press event after reset (prev cleared to 0).

Configuration
REQ-028 Macro KEY_ARBITER_DEBOUNCE_EN defined: per key a counter; filtered level SHALL change only after btn[i] differs from it for DEB_CYCLES consecutive edges; any agreeing sample clears the counter; latency in REQ-023 grows by DEB_CYCLES.
REQ-029 Macro undefined: filtered level SHALL equal btn[i] sampled directly; no counters instantiated.

Verification
REQ-030 No debounce, btn=0001 for 1 cycle then 0, key_ready=1 -> key_valid high 1 cycle, key_id=0, pending=0000 afterwards.
REQ-031 btn 0000->1011 simultaneously, key_ready=1 -> key_id sequence 0,1,3, one idle cycle between offers; then press key 0 again -> key_id=0 (ptr=0 after wrap).
REQ-032 key_ready=0, press key 2 twice (release between) while key 2 is offered then press a third time -> pending=0100 after second press, overrun=1 after third, key_id stays 2.
REQ-033 Assert reset for 1 cycle during OFFER with pending=1010 -> next cycle key_valid=0, pending=0000, overrun=0; btn[1] held high -> key_id=1 offered 2 cycles after reset release.
REQ-034 KEY_ARBITER_DEBOUNCE_EN, DEB_CYCLES=4: btn[3] bounces 1,0,1,1 then steady 1 -> no event until 4 consecutive 1s; exactly one offer with key_id=3.
